// File: rtl/control_sequencer.sv
// control_sequencer
//
// Purpose:
//   Hard-wired control unit for a single-bus CPU datapath. One pass runs a
//   fetch (T0-T2) followed by execute steps (T3-T5, plus T6 for mul/div).
//   All control outputs are registered. Each output register is loaded
//   from the decode of the state being entered, so the outputs always
//   match the current state and ir.
//
// Configuration macro:
//   MULDIV_EN  - when defined, opcodes 16 (mul) and 17 (div) execute and
//                use state T6 to move the high half of Z into HI. When
//                undefined, those opcodes are illegal, T6 does not exist,
//                and hiIn_o/loIn_o are tied low.
//
// Ports:
//   clk_i        system clock, rising-edge active
//   rst_ni       asynchronous active-low reset; forces IDLE outputs at once
//   start_i      level request to begin a pass (sampled only in IDLE)
//   memReady_i   memory read complete (sampled only in T1)
//   ir_i[31:0]   instruction: op=[31:27] Ra=[26:23] Rb=[22:19] Rc=[18:15]
//   busSel_o     encoded bus source (R0-R15=0-15, Zhigh=18, Zlow=19,
//                PC=20, MDR=21, none=31)
//   regIn_o      one-hot R0-R15 write enable
//   marIn_o, pcIn_o, mdrIn_o, irIn_o, yIn_o, zIn_o, hiIn_o, loIn_o,
//   incPc_o, read_o   datapath strobes
//   aluOp_o      ALU operation code, 0 when no ALU operation is active
//   busy_o       high in every state except IDLE
//   done_o       single-cycle pass-complete flag
//   illegal_o    single-cycle illegal-opcode flag (in T2)

module control_sequencer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        memReady_i,
  input  logic [31:0] ir_i,
  output logic [4:0]  busSel_o,
  output logic [15:0] regIn_o,
  output logic        marIn_o,
  output logic        pcIn_o,
  output logic        mdrIn_o,
  output logic        irIn_o,
  output logic        yIn_o,
  output logic        zIn_o,
  output logic        hiIn_o,
  output logic        loIn_o,
  output logic        incPc_o,
  output logic        read_o,
  output logic [4:0]  aluOp_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        illegal_o
);

  // Bus source encodings that this sequencer drives.
  localparam logic [4:0] BusZlow = 5'd19;
  localparam logic [4:0] BusPc   = 5'd20;
  localparam logic [4:0] BusMdr  = 5'd21;
  localparam logic [4:0] BusNone = 5'd31;
`ifdef MULDIV_EN
  localparam logic [4:0] BusZhigh = 5'd18;
`endif

`ifdef MULDIV_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    T6   = 3'd7
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6
  } state_e;
`endif

  // Complete set of registered control outputs.
  typedef struct packed {
    logic [4:0]  busSel;
    logic [15:0] regIn;
    logic [4:0]  aluOp;
    logic        marIn;
    logic        pcIn;
    logic        mdrIn;
    logic        irIn;
    logic        yIn;
    logic        zIn;
`ifdef MULDIV_EN
    logic        hiIn;
    logic        loIn;
`endif
    logic        incPc;
    logic        read;
    logic        busy;
    logic        done;
    logic        illegal;
  } ctrl_t;

  localparam ctrl_t CtrlIdle = '{busSel: BusNone, default: '0};

  state_e stateQ, stateD;
  ctrl_t  ctrlQ, ctrlD;

  // Instruction fields.
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       isAluOp;
  logic       isMulDivOp;
  logic       isLegal;
  logic       unusedIrLow;

  assign opcode = ir_i[31:27];
  assign ra     = ir_i[26:23];
  assign rb     = ir_i[22:19];
  assign rc     = ir_i[18:15];

  // The low instruction bits carry no meaning for the control unit.
  assign unusedIrLow = ^ir_i[14:0];

  assign isAluOp    = (opcode < 5'd16);
  assign isMulDivOp = (opcode == 5'd16) || (opcode == 5'd17);

`ifdef MULDIV_EN
  assign isLegal = isAluOp || isMulDivOp;
`else
  assign isLegal = isAluOp;
`endif

  // Next-state sequencing. Illegal opcodes abort from T2 straight to IDLE.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (start_i) stateD = T0;
      T0:      stateD = T1;
      T1:      if (memReady_i) stateD = T2;
      T2:      stateD = isLegal ? T3 : IDLE;
      T3:      stateD = T4;
      T4:      stateD = T5;
`ifdef MULDIV_EN
      T5:      stateD = isMulDivOp ? T6 : IDLE;
      T6:      stateD = IDLE;
`else
      T5:      stateD = IDLE;
`endif
      default: stateD = IDLE;
    endcase
  end

  // Output decode for the state being entered. PC is loaded only on the
  // T0->T1 transition, so T1 wait cycles do not reload it. Mul/div
  // addresses Ra/Rb in T3/T4, whereas ALU ops use Rb/Rc.
  always_comb begin
    ctrlD      = CtrlIdle;
    ctrlD.busy = (stateD != IDLE);
    case (stateD)
      T0: begin
        ctrlD.busSel = BusPc;
        ctrlD.marIn  = 1'b1;
        ctrlD.incPc  = 1'b1;
        ctrlD.zIn    = 1'b1;
      end
      T1: begin
        ctrlD.busSel = BusZlow;
        ctrlD.pcIn   = (stateQ == T0);
        ctrlD.read   = 1'b1;
        ctrlD.mdrIn  = 1'b1;
      end
      T2: begin
        ctrlD.busSel  = BusMdr;
        ctrlD.irIn    = 1'b1;
        ctrlD.illegal = !isLegal;
      end
      T3: begin
        ctrlD.busSel = {1'b0, (isMulDivOp ? ra : rb)};
        ctrlD.yIn    = 1'b1;
      end
      T4: begin
        ctrlD.busSel = {1'b0, (isMulDivOp ? rb : rc)};
        ctrlD.aluOp  = opcode;
        ctrlD.zIn    = 1'b1;
      end
      T5: begin
        ctrlD.busSel = BusZlow;
`ifdef MULDIV_EN
        if (isMulDivOp) begin
          ctrlD.loIn = 1'b1;
        end else begin
          ctrlD.regIn = 16'h0001 << ra;
          ctrlD.done  = 1'b1;
        end
`else
        ctrlD.regIn = 16'h0001 << ra;
        ctrlD.done  = 1'b1;
`endif
      end
`ifdef MULDIV_EN
      T6: begin
        ctrlD.busSel = BusZhigh;
        ctrlD.hiIn   = 1'b1;
        ctrlD.done   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // State and output registers. Reset returns everything to IDLE values
  // without waiting for the clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stateQ <= IDLE;
      ctrlQ  <= CtrlIdle;
    end else begin
      stateQ <= stateD;
      ctrlQ  <= ctrlD;
    end
  end

  assign busSel_o  = ctrlQ.busSel;
  assign regIn_o   = ctrlQ.regIn;
  assign aluOp_o   = ctrlQ.aluOp;
  assign marIn_o   = ctrlQ.marIn;
  assign pcIn_o    = ctrlQ.pcIn;
  assign mdrIn_o   = ctrlQ.mdrIn;
  assign irIn_o    = ctrlQ.irIn;
  assign yIn_o     = ctrlQ.yIn;
  assign zIn_o     = ctrlQ.zIn;
  assign incPc_o   = ctrlQ.incPc;
  assign read_o    = ctrlQ.read;
  assign busy_o    = ctrlQ.busy;
  assign done_o    = ctrlQ.done;
  assign illegal_o = ctrlQ.illegal;

`ifdef MULDIV_EN
  assign hiIn_o = ctrlQ.hiIn;
  assign loIn_o = ctrlQ.loIn;
`else
  assign hiIn_o = 1'b0;
  assign loIn_o = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//
// Purpose:
//   Self-checking bench for control_sequencer. A table of instruction
//   vectors, randomized passes, and hand-written reset and back-to-back
//   sequences are compared cycle by cycle against a reference model. The
//   model expands each instruction into its expected list of per-cycle
//   control words.
//
// Ports: none (top-level bench).

module tb_control_sequencer;

`ifdef MULDIV_EN
  localparam bit MulDivEn = 1'b1;
`else
  localparam bit MulDivEn = 1'b0;
`endif

  // Strobe positions inside the packed strobe field of a control word.
  localparam logic [9:0] SMar  = 10'h200;
  localparam logic [9:0] SPc   = 10'h100;
  localparam logic [9:0] SMdr  = 10'h080;
  localparam logic [9:0] SIr   = 10'h040;
  localparam logic [9:0] SY    = 10'h020;
  localparam logic [9:0] SZ    = 10'h010;
  localparam logic [9:0] SHi   = 10'h008;
  localparam logic [9:0] SLo   = 10'h004;
  localparam logic [9:0] SInc  = 10'h002;
  localparam logic [9:0] SRead = 10'h001;

  typedef struct packed {
    logic [4:0]  busSel;
    logic [15:0] regIn;
    logic [9:0]  strobes;
    logic [4:0]  aluOp;
    logic        busy;
    logic        done;
    logic        illegal;
  } outVec_t;

  typedef struct {
    logic [31:0] ir;
    int          waits;
    int          expLat;
    logic [15:0] expReg;
    bit          expIll;
  } vecRow_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        memReady;
  logic [31:0] ir;
  logic [4:0]  busSel;
  logic [15:0] regIn;
  logic        marIn, pcIn, mdrIn, irIn, yIn, zIn, hiIn, loIn, incPc, readS;
  logic [4:0]  aluOp;
  logic        busy, done, illegal;

  int testsRun = 0;
  int failures = 0;

  outVec_t expQ[$];
  int      readyQ[$];

  control_sequencer dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .memReady_i (memReady),
    .ir_i       (ir),
    .busSel_o   (busSel),
    .regIn_o    (regIn),
    .marIn_o    (marIn),
    .pcIn_o     (pcIn),
    .mdrIn_o    (mdrIn),
    .irIn_o     (irIn),
    .yIn_o      (yIn),
    .zIn_o      (zIn),
    .hiIn_o     (hiIn),
    .loIn_o     (loIn),
    .incPc_o    (incPc),
    .read_o     (readS),
    .aluOp_o    (aluOp),
    .busy_o     (busy),
    .done_o     (done),
    .illegal_o  (illegal)
  );

  // Free-running clock; rising edges at 10, 20, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic outVec_t idleVec();
    outVec_t v;
    v = '0;
    v.busSel = 5'd31;
    return v;
  endfunction

  function automatic outVec_t busyVec(input logic [4:0] bus, input logic [9:0] str,
                                      input logic [4:0] alu, input logic [15:0] regs,
                                      input logic dn, input logic ill);
    outVec_t v;
    v.busSel  = bus;
    v.regIn   = regs;
    v.strobes = str;
    v.aluOp   = alu;
    v.busy    = 1'b1;
    v.done    = dn;
    v.illegal = ill;
    return v;
  endfunction

  function automatic outVec_t sampleOut();
    outVec_t v;
    v.busSel  = busSel;
    v.regIn   = regIn;
    v.strobes = {marIn, pcIn, mdrIn, irIn, yIn, zIn, hiIn, loIn, incPc, readS};
    v.aluOp   = aluOp;
    v.busy    = busy;
    v.done    = done;
    v.illegal = illegal;
    return v;
  endfunction

  // Reference model: expand one instruction into the control words expected
  // after each clock edge, starting with the edge that samples start. The
  // readyQ entry gives the memReady value to drive after that cycle
  // (-1 means the value is don't-care and is randomized).
  task automatic buildTrace(input logic [31:0] instr, input int waits);
    int op, a, b, c;
    bit aluClass, mdClass;
    op = int'(instr[31:27]);
    a  = int'(instr[26:23]);
    b  = int'(instr[22:19]);
    c  = int'(instr[18:15]);
    aluClass = (op < 16);
    mdClass  = MulDivEn && (op == 16 || op == 17);
    expQ.delete();
    readyQ.delete();
    expQ.push_back(busyVec(5'd20, SMar | SInc | SZ, 5'd0, 16'h0, 1'b0, 1'b0));
    readyQ.push_back(-1);
    for (int j = 0; j <= waits; j++) begin
      expQ.push_back(busyVec(5'd19, SRead | SMdr | ((j == 0) ? SPc : 10'h0),
                             5'd0, 16'h0, 1'b0, 1'b0));
      readyQ.push_back((j == waits) ? 1 : 0);
    end
    expQ.push_back(busyVec(5'd21, SIr, 5'd0, 16'h0, 1'b0, !(aluClass || mdClass)));
    readyQ.push_back(-1);
    if (aluClass) begin
      expQ.push_back(busyVec(5'(b), SY, 5'd0, 16'h0, 1'b0, 1'b0));
      expQ.push_back(busyVec(5'(c), SZ, 5'(op), 16'h0, 1'b0, 1'b0));
      expQ.push_back(busyVec(5'd19, 10'h0, 5'd0, 16'(1 << a), 1'b1, 1'b0));
      repeat (3) readyQ.push_back(-1);
    end else if (mdClass) begin
      expQ.push_back(busyVec(5'(a), SY, 5'd0, 16'h0, 1'b0, 1'b0));
      expQ.push_back(busyVec(5'(b), SZ, 5'(op), 16'h0, 1'b0, 1'b0));
      expQ.push_back(busyVec(5'd19, SLo, 5'd0, 16'h0, 1'b0, 1'b0));
      expQ.push_back(busyVec(5'd18, SHi, 5'd0, 16'h0, 1'b1, 1'b0));
      repeat (4) readyQ.push_back(-1);
    end
  endtask

  task automatic checkOutput(input string name, input outVec_t exp);
    outVec_t act;
    act = sampleOut();
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got bus=%0d reg=%h str=%b alu=%0d busy=%b done=%b ill=%b, expected bus=%0d reg=%h str=%b alu=%0d busy=%b done=%b ill=%b",
               name, act.busSel, act.regIn, act.strobes, act.aluOp, act.busy, act.done,
               act.illegal, exp.busSel, exp.regIn, exp.strobes, exp.aluOp, exp.busy,
               exp.done, exp.illegal);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Run one pass starting at the current negedge. Random start/memReady
  // noise is driven wherever the design must ignore it. With holdStart,
  // start stays high so the next pass follows the single IDLE cycle.
  task automatic applyStimulus(input logic [31:0] instr, input int waits, input bit holdStart,
                               output int endLat, output logic [15:0] regSeen,
                               output bit illSeen);
    int n;
    buildTrace(instr, waits);
    n = expQ.size();
    ir       = instr;
    start    = 1'b1;
    memReady = 1'($urandom_range(0, 1));
    endLat   = -1;
    regSeen  = 16'h0;
    illSeen  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput($sformatf("pass ir=%h cycle %0d", instr, i + 1), expQ[i]);
      if (done || illegal) endLat = i + 1;
      regSeen |= regIn;
      illSeen |= illegal;
      if (holdStart)      start = 1'b1;
      else if (i == n - 1) start = 1'b0;
      else                start = 1'($urandom_range(0, 1));
      memReady = (readyQ[i] < 0) ? 1'($urandom_range(0, 1)) : 1'(readyQ[i]);
    end
    @(negedge clk);
    checkOutput($sformatf("idle after ir=%h", instr), idleVec());
  endtask

  initial begin
    vecRow_t     vectors[7];
    int          lat;
    logic [15:0] regs;
    bit          ill;
    logic [31:0] rnd;
    logic [4:0]  op;

    vectors[0] = '{ir: 32'h4A920000, waits: 0, expLat: 6, expReg: 16'h0020, expIll: 1'b0};
    vectors[1] = '{ir: 32'h4A920000, waits: 3, expLat: 9, expReg: 16'h0020, expIll: 1'b0};
    vectors[2] = '{ir: 32'hF8000000, waits: 0, expLat: 3, expReg: 16'h0000, expIll: 1'b1};
    vectors[3] = '{ir: 32'h81B80000, waits: 0, expLat: (MulDivEn ? 7 : 3),
                   expReg: 16'h0000, expIll: !MulDivEn};
    vectors[4] = '{ir: 32'h7F800000, waits: 1, expLat: 7, expReg: 16'h8000, expIll: 1'b0};
    vectors[5] = '{ir: 32'h90000000, waits: 2, expLat: 5, expReg: 16'h0000, expIll: 1'b1};
    vectors[6] = '{ir: 32'h00000000, waits: 0, expLat: 6, expReg: 16'h0001, expIll: 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    memReady = 1'b0;
    ir       = 32'h0;

    // Reset state, held across clock edges.
    repeat (2) @(negedge clk);
    checkOutput("reset state", idleVec());
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle after release, start low", idleVec());
    @(negedge clk);
    checkOutput("idle stays without start", idleVec());

    // Table-driven vectors: latency, written register, illegal flag.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(vectors[k].ir, vectors[k].waits, 1'b0, lat, regs, ill);
      checkValue($sformatf("vec%0d latency", k), lat, vectors[k].expLat);
      checkValue($sformatf("vec%0d reg_in", k), int'(regs), int'(vectors[k].expReg));
      checkValue($sformatf("vec%0d illegal", k), int'(ill), int'(vectors[k].expIll));
    end

    // Randomized passes against the model, biased toward legal opcodes.
    for (int k = 0; k < 40; k++) begin
      rnd = $urandom();
      case ($urandom_range(0, 3))
        0, 1:    op = 5'($urandom_range(0, 15));
        2:       op = 5'($urandom_range(16, 17));
        default: op = 5'($urandom_range(0, 31));
      endcase
      rnd[31:27] = op;
      applyStimulus(rnd, $urandom_range(0, 3), 1'b0, lat, regs, ill);
    end

    // start held high: back-to-back passes with a single IDLE cycle between.
    applyStimulus(32'h4A920000, 0, 1'b1, lat, regs, ill);
    applyStimulus(32'h4A920000, 1, 1'b1, lat, regs, ill);
    checkValue("back-to-back second latency", lat, 7);
    start = 1'b0;
    @(negedge clk);
    checkOutput("idle after start dropped", idleVec());

    // Asynchronous reset in the middle of T4.
    ir       = 32'h4A920000;
    start    = 1'b1;
    memReady = 1'b1;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("T4 before reset", busyVec(5'd4, SZ, 5'd9, 16'h0, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1 checkOutput("async reset mid-T4", idleVec());
    @(negedge clk);
    checkOutput("reset held across edge", idleVec());
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("no pass without start after reset", idleVec());

    // Asynchronous reset during a T1 wait.
    start    = 1'b1;
    memReady = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("T1 wait before reset", busyVec(5'd19, SRead | SMdr, 5'd0, 16'h0, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1 checkOutput("async reset in T1 wait", idleVec());
    @(negedge clk);
    rst_n    = 1'b1;
    memReady = 1'b1;
    @(negedge clk);
    checkOutput("idle after T1 reset release", idleVec());

    // A fresh pass after reset still works.
    applyStimulus(32'h4A920000, 0, 1'b0, lat, regs, ill);
    checkValue("post-reset latency", lat, 6);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
